mac_mdc_tcdm_bridge: RTL and testbench

//  MP-port flattened TCDM request bridge between the engine's flat TCDM master ports and the cluster interconnect.
//  Per port: one-entry elastic request slice (breaks the req->gnt combinational path) and an outstanding-transaction

---
 rtl/mac_mdc_tcdm_bridge.sv | 113 +++++++++++
 tb/tb_mac_mdc_tcdm_bridge.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_mdc_tcdm_bridge.sv
// mac_mdc_tcdm_bridge: per-port one-entry elastic request slice and outstanding-credit limiter
// between the engine's flat TCDM master ports and the cluster interconnect.
module mac_mdc_tcdm_bridge #(
  parameter int unsigned MP        = 4,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [MP-1:0]        in_req,
  output logic [MP-1:0]        in_gnt,
  input  logic [MP*AW-1:0]     in_add,
  input  logic [MP-1:0]        in_wen,
  input  logic [MP*(DW/8)-1:0] in_be,
  input  logic [MP*DW-1:0]     in_data,
  output logic [MP*DW-1:0]     in_r_data,
  output logic [MP-1:0]        in_r_valid,
  output logic [MP-1:0]        out_req,
  input  logic [MP-1:0]        out_gnt,
  output logic [MP*AW-1:0]     out_add,
  output logic [MP-1:0]        out_wen,
  output logic [MP*(DW/8)-1:0] out_be,
  output logic [MP*DW-1:0]     out_data,
  input  logic [MP*DW-1:0]     out_r_data,
  input  logic [MP-1:0]        out_r_valid,
  output logic                 busy_o,
  output logic [MP-1:0]        err_o
);
  localparam int unsigned BW = DW / 8;
  localparam int unsigned CW = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTST);

  logic [MP-1:0] busy_s;

  assign in_r_valid = out_r_valid;
  assign in_r_data  = out_r_data;
  assign busy_o     = |busy_s;

  for (genvar p = 0; p < MP; p++) begin : g_port
    logic          full_r;
    logic [AW-1:0] add_r;
    logic          wen_r;
    logic [BW-1:0] be_r;
    logic [DW-1:0] data_r;
    logic [CW-1:0] pend_r;
    logic          err_r;
    logic          gnt_s;
    logic          acc_s;
    logic          drn_s;

    // Grant needs a free (or draining) slice and a credit; a same-cycle response frees a credit.
    // Nothing is granted while reset is asserted since the acceptance would be discarded.
    always_comb begin
      gnt_s = 1'b0;
      if (en_i && !rst_i && (!full_r || out_gnt[p]) &&
          ((pend_r < MAX_CNT) || out_r_valid[p])) begin
        gnt_s = 1'b1;
      end else begin
        gnt_s = 1'b0;
      end
      acc_s = in_req[p] & gnt_s;
      drn_s = full_r & out_gnt[p];
    end

    // Request slice: capture on accept (reload when draining the same cycle), empty on drain.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        full_r <= 1'b0;
        add_r  <= {AW{1'b0}};
        wen_r  <= 1'b0;
        be_r   <= {BW{1'b0}};
        data_r <= {DW{1'b0}};
      end else if (acc_s) begin
        full_r <= 1'b1;
        add_r  <= in_add[p*AW +: AW];
        wen_r  <= in_wen[p];
        be_r   <= in_be[p*BW +: BW];
        data_r <= in_data[p*DW +: DW];
      end else if (drn_s) begin
        full_r <= 1'b0;
      end
    end

    // Outstanding credits count from acceptance; an unmatched response is flagged, never underflows.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        pend_r <= {CW{1'b0}};
        err_r  <= 1'b0;
      end else begin
        if (out_r_valid[p] && (pend_r == {CW{1'b0}})) begin
          err_r <= 1'b1;
        end
        if (acc_s && !out_r_valid[p]) begin
          pend_r <= pend_r + CW'(1'b1);
        end else if (!acc_s && out_r_valid[p] && (pend_r != {CW{1'b0}})) begin
          pend_r <= pend_r - CW'(1'b1);
        end
      end
    end

    assign in_gnt[p]            = gnt_s;
    assign out_req[p]           = full_r;
    assign out_add[p*AW +: AW]  = add_r;
    assign out_wen[p]           = wen_r;
    assign out_be[p*BW +: BW]   = be_r;
    assign out_data[p*DW +: DW] = data_r;
    assign err_o[p]             = err_r;
    assign busy_s[p]            = full_r | (pend_r != {CW{1'b0}});
  end

endmodule

// File: tb/tb_mac_mdc_tcdm_bridge.sv
// Self-checking bench for mac_mdc_tcdm_bridge: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_mac_mdc_tcdm_bridge;
  localparam int MP   = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int MAXO = 2;

  logic                clk;
  logic                rst_i;
  logic                en_i;
  logic [MP-1:0]       in_req;
  logic [MP-1:0]       in_gnt;
  logic [MP*AW-1:0]    in_add;
  logic [MP-1:0]       in_wen;
  logic [MP*BW-1:0]    in_be;
  logic [MP*DW-1:0]    in_data;
  logic [MP*DW-1:0]    in_r_data;
  logic [MP-1:0]       in_r_valid;
  logic [MP-1:0]       out_req;
  logic [MP-1:0]       out_gnt;
  logic [MP*AW-1:0]    out_add;
  logic [MP-1:0]       out_wen;
  logic [MP*BW-1:0]    out_be;
  logic [MP*DW-1:0]    out_data;
  logic [MP*DW-1:0]    out_r_data;
  logic [MP-1:0]       out_r_valid;
  logic                busy_o;
  logic [MP-1:0]       err_o;

  mac_mdc_tcdm_bridge #(.MP(MP), .AW(AW), .DW(DW), .MAX_OUTST(MAXO)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i),
    .in_req(in_req), .in_gnt(in_gnt), .in_add(in_add), .in_wen(in_wen),
    .in_be(in_be), .in_data(in_data), .in_r_data(in_r_data), .in_r_valid(in_r_valid),
    .out_req(out_req), .out_gnt(out_gnt), .out_add(out_add), .out_wen(out_wen),
    .out_be(out_be), .out_data(out_data), .out_r_data(out_r_data), .out_r_valid(out_r_valid),
    .busy_o(busy_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] add;
    logic          wen;
    logic [BW-1:0] be;
    logic [DW-1:0] data;
  } req_t;

  // Reference model: what is parked towards the interconnect, and how many accesses await a response.
  bit   m_full [MP];
  req_t m_slice[MP];
  int   m_pend [MP];
  bit   m_err  [MP];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_port(input int p, input logic req, input logic [AW-1:0] add,
                            input logic wen, input logic [BW-1:0] be, input logic [DW-1:0] data);
    in_req[p]            = req;
    in_add[p*AW +: AW]   = add;
    in_wen[p]            = wen;
    in_be[p*BW +: BW]    = be;
    in_data[p*DW +: DW]  = data;
  endtask

  // One clock: compare every output with the model at the falling edge, then advance the model.
  task automatic step();
    logic [MP-1:0] exp_gnt;
    logic [MP-1:0] exp_req;
    logic [MP-1:0] exp_err;
    logic          exp_busy;
    bit            acc;
    bit            drn;
    @(negedge clk);
    exp_busy = 1'b0;
    for (int p = 0; p < MP; p++) begin
      exp_gnt[p] = en_i && !rst_i && (!m_full[p] || out_gnt[p]) &&
                   ((m_pend[p] < MAXO) || out_r_valid[p]);
      exp_req[p] = m_full[p];
      exp_err[p] = m_err[p];
      if (m_full[p] || m_pend[p] != 0) exp_busy = 1'b1;
      if (m_full[p]) begin
        chk($sformatf("out_add[%0d]", p),  out_add[p*AW +: AW],  m_slice[p].add);
        chk($sformatf("out_wen[%0d]", p),  out_wen[p],           m_slice[p].wen);
        chk($sformatf("out_be[%0d]", p),   out_be[p*BW +: BW],   m_slice[p].be);
        chk($sformatf("out_data[%0d]", p), out_data[p*DW +: DW], m_slice[p].data);
      end
    end
    chk("in_gnt", in_gnt, exp_gnt);
    chk("out_req", out_req, exp_req);
    chk("err_o", err_o, exp_err);
    chk("busy_o", busy_o, exp_busy);
    chk("in_r_valid", in_r_valid, out_r_valid);
    chk("in_r_data", in_r_data, out_r_data);
    for (int p = 0; p < MP; p++) begin
      if (rst_i) begin
        m_full[p] = 1'b0;
        m_pend[p] = 0;
        m_err[p]  = 1'b0;
      end else begin
        acc = in_req[p] && exp_gnt[p];
        drn = m_full[p] && out_gnt[p];
        if (out_r_valid[p] && m_pend[p] == 0) m_err[p] = 1'b1;
        m_pend[p] = m_pend[p] + int'(acc) - int'(out_r_valid[p]);
        if (m_pend[p] < 0) m_pend[p] = 0;
        if (acc) begin
          m_full[p]  = 1'b1;
          m_slice[p] = '{add: in_add[p*AW +: AW], wen: in_wen[p],
                         be: in_be[p*BW +: BW], data: in_data[p*DW +: DW]};
        end else if (drn) begin
          m_full[p] = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; en_i = 1'b1;
    in_req = 4'hF; in_wen = 4'hF; in_be = '1; in_add = '0; in_data = '0;
    out_gnt = 4'h0; out_r_valid = 4'h0; out_r_data = '0;
    for (int p = 0; p < MP; p++) begin
      m_full[p] = 1'b0; m_pend[p] = 0; m_err[p] = 1'b0; m_slice[p] = '0;
    end
    @(posedge clk);
    #1;

    // T1: reset with all requests raised
    step();
    chk("t1_gnt_in_reset", in_gnt, 4'h0);
    chk("t1_req_in_reset", out_req, 4'h0);
    chk("t1_busy_in_reset", busy_o, 1'b0);
    chk("t1_err_in_reset", err_o, 4'h0);
    rst_i = 1'b0; en_i = 1'b0;
    step();
    chk("t1_req_after", out_req, 4'h0);
    chk("t1_busy_after", busy_o, 1'b0);
    in_req = 4'h0; en_i = 1'b1;

    // T2: single read, one-cycle request latency, response pass-through
    out_gnt = 4'hF;
    drive_port(0, 1'b1, 32'h0000_0100, 1'b1, 4'hF, 32'h0);
    step();
    chk("t2_out_req", out_req[0], 1'b1);
    chk("t2_out_add", out_add[31:0], 32'h0000_0100);
    drive_port(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    out_r_valid = 4'b0001; out_r_data[31:0] = 32'h0000_CAFE;
    #1;
    chk("t2_r_valid", in_r_valid[0], 1'b1);
    chk("t2_r_data", in_r_data[31:0], 32'h0000_CAFE);
    step();
    out_r_valid = 4'h0;
    step();
    chk("t2_busy_idle", busy_o, 1'b0);

    // T3: backpressure on port 3, two writes kept in order
    out_gnt = 4'h0;
    drive_port(3, 1'b1, 32'h0000_0010, 1'b0, 4'hF, 32'h0000_00A5);
    step();
    drive_port(3, 1'b1, 32'h0000_0014, 1'b0, 4'h3, 32'h0000_005A);
    #1;
    chk("t3_gnt_blocked", in_gnt[3], 1'b0);
    repeat (5) begin
      step();
      chk("t3_hold_add", out_add[3*AW +: AW], 32'h0000_0010);
      chk("t3_hold_data", out_data[3*DW +: DW], 32'h0000_00A5);
    end
    out_gnt[3] = 1'b1;
    #1;
    chk("t3_gnt_on_drain", in_gnt[3], 1'b1);
    step();
    chk("t3_second_add", out_add[3*AW +: AW], 32'h0000_0014);
    in_req[3] = 1'b0;
    step();
    chk("t3_drained", out_req[3], 1'b0);
    out_r_valid = 4'b1000;
    step(); step();
    out_r_valid = 4'h0;

    // T4: credit limit of two on port 1
    out_gnt = 4'hF;
    drive_port(1, 1'b1, 32'h0000_0200, 1'b1, 4'hF, 32'h0);
    step(); step();
    #1;
    chk("t4_gnt_at_limit", in_gnt[1], 1'b0);
    step();
    chk("t4_gnt_still_blocked", in_gnt[1], 1'b0);
    out_r_valid = 4'b0010;
    #1;
    chk("t4_gnt_with_resp", in_gnt[1], 1'b1);
    step();
    out_r_valid = 4'h0;
    #1;
    chk("t4_gnt_blocked_again", in_gnt[1], 1'b0);
    in_req[1] = 1'b0; out_r_valid = 4'b0010;
    step(); step();
    out_r_valid = 4'h0;
    step();

    // T5: unmatched response on port 2
    out_gnt = 4'h0; in_req = 4'h0;
    out_r_valid = 4'b0100;
    step();
    out_r_valid = 4'h0;
    chk("t5_err_set", err_o, 4'b0100);
    step(); step();
    chk("t5_err_sticky", err_o, 4'b0100);
    chk("t5_no_pend", busy_o, 1'b0);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("t5_err_cleared", err_o, 4'h0);

    // T6: drain with one buffered and two outstanding, then reset mid-burst
    out_gnt[0] = 1'b1;
    drive_port(0, 1'b1, 32'h0000_0300, 1'b1, 4'hF, 32'h1);
    step();
    drive_port(0, 1'b1, 32'h0000_0304, 1'b1, 4'hF, 32'h2);
    step();
    en_i = 1'b0; out_gnt[0] = 1'b0;
    #1;
    chk("t6_no_gnt", in_gnt[0], 1'b0);
    step();
    chk("t6_buffered_add", out_add[31:0], 32'h0000_0304);
    out_gnt[0] = 1'b1;
    step();
    out_gnt[0] = 1'b0;
    chk("t6_busy_pending", busy_o, 1'b1);
    out_r_valid = 4'b0001;
    step();
    chk("t6_busy_one_left", busy_o, 1'b1);
    step();
    out_r_valid = 4'h0;
    chk("t6_busy_done", busy_o, 1'b0);
    en_i = 1'b1;
    for (int p = 0; p < MP; p++) drive_port(p, 1'b1, 32'h400 + 32'(p), 1'b0, 4'hF, 32'(p));
    step();
    chk("t6_burst_req", out_req, 4'hF);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0; in_req = 4'h0;
    chk("t6_rst_req", out_req, 4'h0);
    chk("t6_rst_busy", busy_o, 1'b0);
    step();

    // Random traffic against the model
    for (int c = 0; c < 800; c++) begin
      rst_i = ($urandom_range(0, 149) == 0);
      en_i  = ($urandom_range(0, 7) != 0);
      for (int p = 0; p < MP; p++) begin
        drive_port(p, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 15)), $urandom);
        out_gnt[p]               = ($urandom_range(0, 3) != 0);
        out_r_valid[p]           = (m_pend[p] > 0) && ($urandom_range(0, 2) == 0);
        out_r_data[p*DW +: DW]   = $urandom;
      end
      step();
    end

    // Let everything settle and confirm the bridge goes idle
    rst_i = 1'b0; en_i = 1'b0; in_req = 4'h0; out_gnt = 4'hF;
    for (int c = 0; c < 8; c++) begin
      for (int p = 0; p < MP; p++) out_r_valid[p] = (m_pend[p] > 0);
      step();
    end
    out_r_valid = 4'h0;
    step();
    chk("final_idle", busy_o, 1'b0);
    chk("final_err", err_o, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
